// File: rtl/ascii_seq_pkg.sv
// ascii_seq_pkg: shared states and character constants for the ASCII stream sequencer
package ascii_seq_pkg;
  typedef enum logic [1:0] {IDLE, SEND, CRLF} state_e;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int HEX_LEN = 4;
  localparam int BIN_LEN = 16;
endpackage

// File: rtl/ascii_char_select.sv
// ascii_char_select: maps latched value, mode and digit index to one ASCII character
module ascii_char_select
  import ascii_seq_pkg::*;
(
  input  logic [15:0] value_i,
  input  logic        mode_i,
  input  logic [3:0]  idx_i,
  output logic [7:0]  char_o
);
  logic [3:0] nib;
  // Digits go out most significant first, so the index counts down through the word
  assign nib = value_i[{~idx_i[1:0], 2'b00} +: 4];
  assign char_o = mode_i ? (value_i[~idx_i] ? ASCII_ZERO + 8'd1 : ASCII_ZERO)
                         : (nib < 4'd10 ? ASCII_ZERO + {4'h0, nib} : ASCII_A + {4'h0, nib} - 8'd10);
endmodule

// File: rtl/ascii_stream_sequencer.sv
// ascii_stream_sequencer: streams a 16-bit value as hex or binary ASCII over valid/ready.
// Define ASCII_SEQ_CRLF_EN to terminate each frame with CR LF.
module ascii_stream_sequencer
  import ascii_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        mode,
  input  logic        start,
  output logic        ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);
  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] value_q, value_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [4:0]  last;
  logic [7:0]  ch;

  ascii_char_select u_sel (
    .value_i(value_q),
    .mode_i (mode_q),
    .idx_i  (idx_q[3:0]),
    .char_o (ch)
  );

  assign last = mode_q ? 5'(BIN_LEN - 1) : 5'(HEX_LEN - 1);

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    value_d = value_q;
    mode_d = mode_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        idx_d = 5'd0;
        value_d = value;
        mode_d = mode;
      end
      SEND: if (tx_ready) begin
        if (idx_q == last) begin
          idx_d = 5'd0;
`ifdef ASCII_SEQ_CRLF_EN
          state_d = CRLF;
`else
          state_d = IDLE;
          done_d = 1'b1;
`endif
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      CRLF: if (tx_ready) begin
        idx_d = idx_q[0] ? 5'd0 : 5'd1;
        state_d = idx_q[0] ? IDLE : CRLF;
        done_d = idx_q[0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= 5'd0;
      value_q <= 16'h0000;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      value_q <= value_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  // Outputs decode only registered state, so tx_ready and start never reach them
  assign ready = state_q == IDLE;
  assign tx_valid = state_q != IDLE;
  assign done = done_q;
  assign tx_data = state_q == SEND ? ch : state_q == CRLF ? (idx_q[0] ? ASCII_LF : ASCII_CR) : 8'h00;
endmodule

// File: tb/tb_ascii_stream_sequencer.sv
// tb_ascii_stream_sequencer: directed checks of framing, backpressure, reset and back-to-back starts
module tb_ascii_stream_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        mode = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        done;
  int          checks = 0;
  int          errors = 0;
  string       sfx;

  ascii_stream_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value   (value),
    .mode    (mode),
    .start   (start),
    .ready   (ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Starts a frame in the current cycle and checks every character cycle by cycle
  task automatic run_frame(input string tag, input logic [15:0] v, input logic m, input string exp,
                           input int stall_idx, input int stall_n, input int poke_idx);
    chk({tag, "_ready_pre"}, ready, 1'b1);
    start = 1'b1;
    value = v;
    mode = m;
    tick();
    start = 1'b0;
    value = ~v;
    mode = ~m;
    for (int i = 0; i < exp.len(); i++) begin
      if (i == poke_idx) begin
        start = 1'b1;
        value = 16'h0000;
      end
      if (i == stall_idx) begin
        tx_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk({tag, "_stall_valid"}, tx_valid, 1'b1);
          chk({tag, "_stall_data"}, tx_data, exp[i]);
          tick();
        end
        tx_ready = 1'b1;
      end
      chk({tag, "_valid"}, tx_valid, 1'b1);
      chk({tag, "_data"}, tx_data, exp[i]);
      chk({tag, "_done_early"}, done, 1'b0);
      chk({tag, "_ready_busy"}, ready, 1'b0);
      tick();
      start = 1'b0;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_ready_post"}, ready, 1'b1);
    chk({tag, "_valid_post"}, tx_valid, 1'b0);
  endtask

  initial begin
`ifdef ASCII_SEQ_CRLF_EN
    sfx = "\r\n";
`else
    sfx = "";
`endif
    #2;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame("hex1a3f", 16'h1A3F, 1'b0, {"1A3F", sfx}, -1, 0, -1);
    tick();
    chk("done_pulse", done, 1'b0);
    run_frame("bin8001", 16'h8001, 1'b1, {"1000000000000001", sfx}, -1, 0, 5);
    tick();
    run_frame("beef", 16'hBEEF, 1'b0, {"BEEF", sfx}, 1, 3, 2);
    run_frame("b2b", 16'h00FF, 1'b0, {"00FF", sfx}, -1, 0, -1);
    run_frame("hexc5", 16'h09C5, 1'b0, {"09C5", sfx}, 0, 1, -1);
    start = 1'b1;
    value = 16'h8001;
    mode = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("mid_data", tx_data, 8'h30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_valid", tx_valid, 1'b0);
    run_frame("after_rst", 16'h5A01, 1'b1, {"0101101000000001", sfx}, 15, 2, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
